bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Sequences access to the shared coherence bus and RAM port among NREQ cores; each core has a data-side request (read, write-back or invalidate) and an instruction-fetch request.
- Picks one winner at a time, holds the grant until the transaction sequencer signals completion, then releases it.
- Data requests round-robin across cores and beat instruction requests, except that an instruction request aged past MAX_WAIT is promoted above data.
- Includes a hang watchdog on the held grant.

Parameters:
NREQ, 2, number of requesting cores (>=2)
MAX_WAIT, 8, cycles an ifetch may wait before promotion (>=1)
TIMEOUT, 256, cycles a grant may be held without done before err is set

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
dreq  in  NREQ  per-core data-side request (dREN|dWEN|cctrans); level, held until granted
ireq  in  NREQ  per-core ifetch request (iREN); level, held until granted
done  in  1  one-cycle pulse from the sequencer: current transaction finished
gnt_valid  out  1  a grant is active
gnt_id  out  $clog2(NREQ)  core holding the grant
gnt_is_i  out  1  1 = grant is for ifetch, 0 = grant is for data
busy  out  1  state != IDLE
err  out  1  sticky; set when the watchdog expires

Behaviour:
- Reset (async, any state):
  - state=IDLE, rr_ptr=0, all ages=0, watchdog=0.
  - gnt_valid=0, gnt_id=0, gnt_is_i=0, err=0.
- All outputs are registered.
- State IDLE:
  - If any dreq or ireq bit is set, latch a winner (see arbitration) into gnt_id and gnt_is_i, set gnt_valid=1 and go to GRANT.
  - Request-to-grant latency is exactly 1 cycle.
  - With no request, stay in IDLE.
- State GRANT:
  - gnt_id and gnt_is_i are frozen; gnt_valid=1.
  - Dropping the granted request does not abort the grant.
  - done=1: next cycle gnt_valid=0, state goes to GAP, and rr_ptr=(gnt_id+1) mod NREQ. rr_ptr advances for both data and ifetch grants.
- State GAP:
  - One cycle with gnt_valid=0 so the requester can lower its request; go to IDLE.
  - done is ignored in IDLE and GAP.
  - Minimum spacing between grants: done, GAP, IDLE, new grant, so 3 cycles from done to the next gnt_valid rise.
- Arbitration (combinational in IDLE; scan order is rr_ptr, rr_ptr+1, ... wrapping modulo NREQ):
  1. Aged ifetch: the first i in scan order with ireq[i] and age[i]==MAX_WAIT; gnt_is_i=1.
  2. Otherwise the first i with dreq[i]; gnt_is_i=0.
  3. Otherwise the first i with ireq[i]; gnt_is_i=1.
  - If dreq[i] and ireq[i] are both set and no ifetch is aged, the data side wins.
- Age counters (one per core, width $clog2(MAX_WAIT+1)):
  - Cleared when ireq[i]=0, or when an ifetch grant to core i is issued.
  - Otherwise increment by 1 each cycle, saturating at MAX_WAIT.
  - Counting continues during GRANT and GAP.
- Watchdog:
  - Counts cycles spent in GRANT and clears on leaving GRANT.
  - Reaching TIMEOUT sets err=1. err stays set until RST.
  - The grant is not revoked on timeout.
- Simultaneous events:
  - done and new requests in the same cycle: the requests are only considered in the IDLE that follows GAP.
  - RST during GRANT drops gnt_valid asynchronously; no done is expected afterwards.

Decomposition:
- Shared package cpu_types_pkg gets:
  - enum arb_state_t {IDLE, GRANT, GAP}
  - localparam ARB_ID_W = $clog2(NREQ)
- One sub-module, rr_pick: a pure combinational find-first-set starting from rr_ptr with wrap-around.
  - Inputs: req vector, rr_ptr. Outputs: found, idx.
  - Instantiated three times: aged-ifetch, data, ifetch.
- The bus_arbiter top holds the FSM, rr_ptr, the age counters and the watchdog.

Test Plan (NREQ=2, MAX_WAIT=4, TIMEOUT=16):
- Reset, then dreq=2'b11 held; done pulses 2 cycles after each grant. Expect gnt_id sequence 0,1,0,1 with gnt_is_i=0, and gnt_valid rising 1 cycle after the request and 3 cycles after each done.
- dreq[0]=1 and ireq[1]=1 at the same cycle. Expect a data grant to core 0 first, then after done an ifetch grant to core 1 (gnt_id=1, gnt_is_i=1).
- ireq[1] held while core 0 issues back-to-back dreq, with grants held 3 cycles each. Expect core 1 promoted once age[1]=4: the next grant is gnt_id=1, gnt_is_i=1 even though dreq[0]=1.
- Grant issued and done never pulsed. Expect err=1 exactly 16 cycles after entering GRANT, gnt_valid still 1; a later done still releases the grant and err stays 1.
- RST asserted mid-GRANT. Expect gnt_valid, busy and err to go to 0 immediately without waiting for CLK; rr_ptr=0, so with dreq=2'b11 after release core 0 wins first.
- A done pulse while in IDLE with no requests. Expect no state change and gnt_valid to stay 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the bus arbiter slice.
// Revision: 1.0
`default_nettype none

package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int ARB_NREQ = 2;
  localparam int ARB_ID_W = $clog2(ARB_NREQ);

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational find-first-set starting at rr_ptr, wrapping modulo N_REQ.
// Revision: 1.0
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int ID_W = $clog2(N_REQ);

  int w_pos;

  // Walk the scan order backwards so the earliest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_pos = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = (int'(rr_ptr) + k) % N_REQ;
      if (req[w_pos[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = w_pos[ID_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin grant of the coherence bus / RAM port among cores,
// data over ifetch unless an ifetch has aged past MAX_WAIT; grant-hold watchdog.
// Revision: 1.0
`default_nettype none

module bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         dreq,
  input  logic [NREQ-1:0]         ireq,
  input  logic                    done,
  output logic                    gnt_valid,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    gnt_is_i,
  output logic                    busy,
  output logic                    err
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [ID_W-1:0]  c_id_last = ID_W'(NREQ - 1);
  localparam logic [AGE_W-1:0] c_age_max = AGE_W'(MAX_WAIT);
  localparam logic [WD_W-1:0]  c_wd_last = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  c_wd_max  = WD_W'(TIMEOUT);

  arb_state_t       r_state, w_next;
  logic [ID_W-1:0]  r_rr_ptr, r_gnt_id;
  logic             r_gnt_valid, r_gnt_is_i, r_busy, r_err;
  logic [AGE_W-1:0] r_age [NREQ];
  logic [WD_W-1:0]  r_wd;

  logic [NREQ-1:0]  w_aged;
  logic             w_aged_found, w_d_found, w_i_found;
  logic [ID_W-1:0]  w_aged_idx, w_d_idx, w_i_idx;
  logic [ID_W-1:0]  w_win_id;
  logic             w_win_is_i, w_issue;

  always_comb begin
    w_aged = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_aged[i] = ireq[i] && (r_age[i] == c_age_max);
    end
  end

  rr_pick #(.N_REQ(NREQ)) u_pick_aged (
    .req(w_aged), .rr_ptr(r_rr_ptr), .found(w_aged_found), .idx(w_aged_idx)
  );
  rr_pick #(.N_REQ(NREQ)) u_pick_data (
    .req(dreq),   .rr_ptr(r_rr_ptr), .found(w_d_found),    .idx(w_d_idx)
  );
  rr_pick #(.N_REQ(NREQ)) u_pick_ifetch (
    .req(ireq),   .rr_ptr(r_rr_ptr), .found(w_i_found),    .idx(w_i_idx)
  );

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    w_win_id   = w_i_idx;
    w_win_is_i = 1'b1;
    if (w_aged_found) begin
      w_win_id   = w_aged_idx;
      w_win_is_i = 1'b1;
    end else if (w_d_found) begin
      w_win_id   = w_d_idx;
      w_win_is_i = 1'b0;
    end
    case (r_state)
      IDLE: begin
        if (w_aged_found || w_d_found || w_i_found) begin
          w_issue = 1'b1;
          w_next  = GRANT;
        end
      end
      GRANT:   if (done) w_next = GAP;
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_gnt_is_i  <= 1'b0;
      r_busy      <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_busy <= (w_next != IDLE);
      if (w_issue) begin
        r_gnt_valid <= 1'b1;
        r_gnt_id    <= w_win_id;
        r_gnt_is_i  <= w_win_is_i;
      end else if (r_state == GRANT && done) begin
        r_gnt_valid <= 1'b0;
        r_rr_ptr    <= (r_gnt_id == c_id_last) ? '0 : r_gnt_id + ID_W'(1);
      end
    end
  end

  // Ages keep running through GRANT and GAP so a starved ifetch is ready at the next IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREQ; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!ireq[i] || (w_issue && w_win_is_i && w_win_id == ID_W'(i)))
          r_age[i] <= '0;
        else if (r_age[i] != c_age_max)
          r_age[i] <= r_age[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else if (r_state == GRANT) begin
      if (r_wd == c_wd_last) r_err <= 1'b1;
      if (done)                  r_wd <= '0;
      else if (r_wd != c_wd_max) r_wd <= r_wd + WD_W'(1);
    end else begin
      r_wd <= '0;
    end
  end

  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign gnt_is_i  = r_gnt_is_i;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized + directed scoreboard bench for bus_arbiter.
// Revision: 1.0
`default_nettype none

module tb_bus_arbiter;

  localparam int NREQ     = 2;
  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 16;

  localparam int M_IDLE  = 0;
  localparam int M_GRANT = 1;
  localparam int M_GAP   = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NREQ-1:0] dreq = '0;
  logic [NREQ-1:0] ireq = '0;
  logic            done = 1'b0;
  logic            gnt_valid, gnt_is_i, busy, err;
  logic [$clog2(NREQ)-1:0] gnt_id;

  bus_arbiter #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .dreq(dreq), .ireq(ireq), .done(done),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_is_i(gnt_is_i),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit gv;
    bit bsy;
    bit er;
    int id;
    bit is_i;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: ages as "cycles since last clear", watchdog as "cycles since grant".
  int m_st, m_ptr, m_gid, m_n, m_gedge;
  bit m_gi, m_err, m_newg;
  int m_since [NREQ];

  task automatic model_reset();
    m_st = M_IDLE; m_ptr = 0; m_gid = 0; m_gi = 0; m_n = 0;
    m_gedge = 0; m_err = 0; m_newg = 0;
    for (int i = 0; i < NREQ; i++) m_since[i] = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] d, input logic [NREQ-1:0] iv, input logic dn);
    int age;
    int best_rank, best_j, rank, j;
    m_n++;
    m_newg = 0;
    if (m_st == M_GRANT && (m_n - m_gedge) == TIMEOUT) m_err = 1;
    if (m_st == M_IDLE) begin
      best_rank = 3; best_j = 0;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        age = (m_n - 1) - m_since[j];
        if (age > MAX_WAIT) age = MAX_WAIT;
        if (iv[j] && age == MAX_WAIT) rank = 0;
        else if (d[j])                rank = 1;
        else if (iv[j])               rank = 2;
        else                          rank = 3;
        if (rank < best_rank) begin best_rank = rank; best_j = j; end
      end
      if (best_rank < 3) begin
        m_gid = best_j; m_gi = (best_rank != 1);
        m_gedge = m_n; m_newg = 1; m_st = M_GRANT;
      end
    end else if (m_st == M_GRANT) begin
      if (dn) begin m_ptr = (m_gid + 1) % NREQ; m_st = M_GAP; end
    end else begin
      m_st = M_IDLE;
    end
    for (int i = 0; i < NREQ; i++)
      if (!iv[i] || (m_newg && m_gi && m_gid == i)) m_since[i] = m_n;
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, return just after the edge.
  task automatic tick(input logic [NREQ-1:0] d, input logic [NREQ-1:0] iv, input logic dn);
    exp_t e;
    @(negedge CLK);
    dreq = d; ireq = iv; done = dn;
    model_step(d, iv, dn);
    e.gv = (m_st == M_GRANT); e.bsy = (m_st != M_IDLE); e.er = m_err;
    e.id = m_gid; e.is_i = m_gi;
    exp_q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset(input bit check_async);
    #1 RST = 1'b1;
    #1;
    if (check_async) begin
      chk("async_rst_gnt_valid", int'(gnt_valid), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_err", int'(err), 0);
    end
    model_reset();
    RST = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt_valid", int'(gnt_valid), int'(e.gv));
        chk("busy", int'(busy), int'(e.bsy));
        chk("err", int'(err), int'(e.er));
        if (e.gv) begin
          chk("gnt_id", int'(gnt_id), e.id);
          chk("gnt_is_i", int'(gnt_is_i), int'(e.is_i));
        end
      end
    end
  end

  initial begin : stim
    logic [NREQ-1:0] rd, ri;
    logic dn;
    int hold;
    model_reset();
    #3;
    chk("rst_gnt_valid", int'(gnt_valid), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_gnt_is_i", int'(gnt_is_i), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    // Randomized traffic: requests held until their grant's done, random hold lengths.
    rd = '0; ri = '0; hold = 0;
    repeat (1500) begin
      dn = 1'b0;
      if (m_st == M_GRANT) begin
        if (hold <= 1) begin
          dn = 1'b1;
          for (int i = 0; i < NREQ; i++)
            if (i == m_gid) begin
              if (m_gi) ri[i] = 1'b0; else rd[i] = 1'b0;
            end
        end else hold--;
      end else if ($urandom_range(7) == 0) dn = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (!rd[i] && $urandom_range(3) == 0) rd[i] = 1'b1;
        if (!ri[i] && $urandom_range(4) == 0) ri[i] = 1'b1;
      end
      tick(rd, ri, dn);
      if (m_newg) hold = int'($urandom_range(4, 1));
    end

    // Both cores requesting data: strict alternation, 3 cycles from done to next grant.
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      tick(2'b11, 2'b00, 1'b0);
      chk("alt_gnt_valid", int'(gnt_valid), 1);
      chk("alt_gnt_id", int'(gnt_id), k % 2);
      chk("alt_gnt_is_i", int'(gnt_is_i), 0);
      tick(2'b11, 2'b00, 1'b0);
      tick(2'b11, 2'b00, 1'b1);
      chk("alt_gap_valid", int'(gnt_valid), 0);
      tick(2'b11, 2'b00, 1'b0);
      chk("alt_idle_valid", int'(gnt_valid), 0);
    end

    // Data beats ifetch, then the ifetch is served.
    do_reset(0);
    tick(2'b01, 2'b10, 1'b0);
    chk("dvi_first_id", int'(gnt_id), 0);
    chk("dvi_first_is_i", int'(gnt_is_i), 0);
    tick(2'b01, 2'b10, 1'b1);
    tick(2'b00, 2'b10, 1'b0);
    tick(2'b00, 2'b10, 1'b0);
    chk("dvi_second_valid", int'(gnt_valid), 1);
    chk("dvi_second_id", int'(gnt_id), 1);
    chk("dvi_second_is_i", int'(gnt_is_i), 1);
    tick(2'b00, 2'b10, 1'b1);
    tick(2'b00, 2'b00, 1'b0);

    // Aged ifetch promoted above a continuous data request.
    do_reset(0);
    tick(2'b01, 2'b10, 1'b0);
    chk("age_first_is_i", int'(gnt_is_i), 0);
    tick(2'b01, 2'b10, 1'b0);
    tick(2'b01, 2'b10, 1'b0);
    tick(2'b01, 2'b10, 1'b1);
    tick(2'b01, 2'b10, 1'b0);
    tick(2'b01, 2'b10, 1'b0);
    chk("age_promo_valid", int'(gnt_valid), 1);
    chk("age_promo_id", int'(gnt_id), 1);
    chk("age_promo_is_i", int'(gnt_is_i), 1);
    tick(2'b01, 2'b00, 1'b1);
    tick(2'b00, 2'b00, 1'b0);

    // Watchdog: err exactly TIMEOUT cycles into an unreleased grant.
    do_reset(0);
    tick(2'b01, 2'b00, 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick(2'b00, 2'b00, 1'b0);
      if (k == TIMEOUT - 1) chk("wd_err_early", int'(err), 0);
      if (k == TIMEOUT) begin
        chk("wd_err_set", int'(err), 1);
        chk("wd_grant_kept", int'(gnt_valid), 1);
      end
    end
    tick(2'b00, 2'b00, 1'b1);
    chk("wd_release_valid", int'(gnt_valid), 0);
    chk("wd_err_sticky", int'(err), 1);
    tick(2'b00, 2'b00, 1'b0);

    // Asynchronous reset in the middle of a grant clears rr_ptr as well.
    tick(2'b11, 2'b00, 1'b0);
    chk("pre_rst_id", int'(gnt_id), 1);
    do_reset(1);
    tick(2'b11, 2'b00, 1'b0);
    chk("post_rst_id", int'(gnt_id), 0);
    chk("post_rst_is_i", int'(gnt_is_i), 0);
    tick(2'b11, 2'b00, 1'b1);
    tick(2'b00, 2'b00, 1'b0);

    // done while idle is ignored.
    tick(2'b00, 2'b00, 1'b1);
    chk("idle_done_valid", int'(gnt_valid), 0);
    chk("idle_done_busy", int'(busy), 0);
    tick(2'b00, 2'b00, 1'b0);
    chk("idle_after_valid", int'(gnt_valid), 0);

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
